dac_sample_tx: RTL and testbench

Output-side sample transmitter for the low-pass filter chain. It accepts one signed 32-bit filtered sample per handshake and saturates it to the DAC word width. It then shifts the word MSB-first to an external serial DAC over a three-wire interface: clock, data, and active-low frame sync. It is the consumer end of the filter's `out` sample stream.

---
 rtl/dac_sample_tx.sv | 131 +++++++++++++
 tb/tb_dac_sample_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_tx.sv
// Saturating sample-to-serial-DAC transmitter: one signed sample in, one MSB-first framed word out.
// First serial bit one cycle after accept; in_ready only in IDLE, so each sample holds off the next for a full frame plus gap.
module dac_sample_tx #(
  parameter int no_bits  = 32,
  parameter int dac_bits = 16,
  parameter int clk_div  = 4
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic signed [no_bits-1:0] in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sat_clr,
  output logic                      dac_sclk,
  output logic                      dac_sdata,
  output logic                      dac_sync_n,
  output logic                      busy,
  output logic                      sat
);

  localparam int DW = $clog2(2 * clk_div);
  localparam int BW = $clog2(dac_bits);

  localparam logic [DW-1:0] DIV_LAST = DW'(2 * clk_div - 1);
  localparam logic [DW-1:0] HALF     = DW'(clk_div);
  localparam logic [DW-1:0] GAP_LAST = DW'(clk_div - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(dac_bits - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  localparam logic signed [no_bits-1:0] MAX_V = {{(no_bits-dac_bits+1){1'b0}}, {(dac_bits-1){1'b1}}};
  localparam logic signed [no_bits-1:0] MIN_V = {{(no_bits-dac_bits+1){1'b1}}, {(dac_bits-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [dac_bits-1:0] shreg_q, shreg_d;
  logic                sclk_q, sclk_d;
  logic                sync_n_q, sync_n_d;
  logic                sat_q, sat_d;

  logic                clip_hi, clip_lo;
  logic [dac_bits-1:0] word;

  assign clip_hi = in > MAX_V;
  assign clip_lo = in < MIN_V;

  always_comb begin
    if (clip_hi)      word = {1'b0, {(dac_bits-1){1'b1}}};
    else if (clip_lo) word = {1'b1, {(dac_bits-1){1'b0}}};
    else              word = in[dac_bits-1:0];
  end

  assign in_ready   = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE);
  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_sdata  = shreg_q[dac_bits-1];
  assign sat        = sat_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    sat_d    = sat_q;
    if (sat_clr) sat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = SHIFT;
          div_d    = '0;
          bit_d    = '0;
          shreg_d  = word;
          sclk_d   = 1'b1;
          sync_n_d = 1'b0;
          // a clipped accept overrides a same-cycle clear
          if (clip_hi || clip_lo) sat_d = 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d  = GAP;
            shreg_d  = '0;
            sclk_d   = 1'b0;
            sync_n_d = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_ONE;
            shreg_d = {shreg_q[dac_bits-2:0], 1'b0};
            sclk_d  = 1'b1;
          end
        end else begin
          div_d  = div_q + DIV_ONE;
          sclk_d = (div_q + DIV_ONE) < HALF;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) state_d = IDLE;
        else                   div_d   = div_q + DIV_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b1;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_dac_sample_tx.sv
// Directed bench for dac_sample_tx: default instance plus an 8-bit, clk_div=1 instance.
module tb_dac_sample_tx;

  logic               CLK;
  logic               reset;
  logic signed [31:0] din;
  logic               in_valid;
  logic               in_ready;
  logic               sat_clr;
  logic               dac_sclk, dac_sdata, dac_sync_n, busy, sat;

  logic signed [31:0] din8;
  logic               in_valid8;
  logic               in_ready8;
  logic               sat_clr8;
  logic               sclk8, sdata8, sync_n8, busy8, sat8;

  int checks = 0;
  int errors = 0;

  dac_sample_tx u_dut (
    .CLK(CLK), .reset(reset), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .sat_clr(sat_clr), .dac_sclk(dac_sclk), .dac_sdata(dac_sdata),
    .dac_sync_n(dac_sync_n), .busy(busy), .sat(sat)
  );

  dac_sample_tx #(.no_bits(32), .dac_bits(8), .clk_div(1)) u_dut8 (
    .CLK(CLK), .reset(reset), .in(din8), .in_valid(in_valid8), .in_ready(in_ready8),
    .sat_clr(sat_clr8), .dac_sclk(sclk8), .dac_sdata(sdata8),
    .dac_sync_n(sync_n8), .busy(busy8), .sat(sat8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the accept cycle T with din/in_valid driven; returns at the
  // negedge of the cycle in which in_ready is next seen (rdy = offset from T).
  task automatic frame(input logic hold, input logic signed [31:0] nxt,
                       output logic [15:0] word, output int nfall, output int first_low,
                       output int last_low, output int lowcnt, output int gapc,
                       output logic sat1, output int rdy);
    logic ps;
    word = '0; nfall = 0; first_low = -1; last_low = -1; lowcnt = 0; gapc = 0;
    sat1 = 1'b0; rdy = -1;
    chk("accept_rdy", {31'd0, in_ready}, 32'd1);
    ps = dac_sclk;
    @(posedge CLK); #1;
    sat_clr = 1'b0;
    if (hold) din = nxt;
    else      in_valid = 1'b0;
    for (int c = 1; c <= 145; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        sat1 = sat;
        chk("t1_sclk", {31'd0, dac_sclk}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
      end
      if (ps && !dac_sclk) begin
        word = {word[14:0], dac_sdata};
        nfall++;
      end
      if (!dac_sync_n) begin
        if (first_low < 0) first_low = c;
        last_low = c;
        lowcnt++;
      end
      if (busy && dac_sync_n) gapc++;
      ps = dac_sclk;
      if (in_ready) begin
        rdy = c;
        break;
      end
    end
  endtask

  task automatic start(input logic signed [31:0] v);
    @(posedge CLK); #1;
    din = v;
    in_valid = 1'b1;
    @(negedge CLK);
  endtask

  logic [15:0] w;
  int          nf, fl, ll, lc, gc, rd, wc;
  logic        s1, ps8;

  initial begin
    reset = 1'b1; din = '0; in_valid = 1'b0; sat_clr = 1'b0;
    din8 = '0; in_valid8 = 1'b0; sat_clr8 = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_sclk",     {31'd0, dac_sclk}, 32'd0);
    chk("rst_sdata",    {31'd0, dac_sdata}, 32'd0);
    chk("rst_sync_n",   {31'd0, dac_sync_n}, 32'd1);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_sat",      {31'd0, sat}, 32'd0);

    // Plain word; accept in the first cycle after reset release
    @(posedge CLK); #1;
    reset = 1'b0; din = 1000; in_valid = 1'b1;
    @(negedge CLK);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("plain_word", {16'd0, w}, 32'h03E8);
    chk("plain_nfall", nf, 16);
    chk("plain_first_low", fl, 1);
    chk("plain_last_low", ll, 128);
    chk("plain_lowcnt", lc, 128);
    chk("plain_gap", gc, 4);
    chk("plain_sat", {31'd0, s1}, 32'd0);
    chk("plain_rdy", rd, 133);

    start(100000);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("pos_clip_word", {16'd0, w}, 32'h7FFF);
    chk("pos_clip_sat", {31'd0, s1}, 32'd1);

    start(-40000);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("neg_clip_word", {16'd0, w}, 32'h8000);
    chk("neg_clip_sat", {31'd0, sat}, 32'd1);

    // Clear and clipped accept in the same cycle: set wins, a lone clear afterwards clears
    @(posedge CLK); #1;
    din = 70000; in_valid = 1'b1; sat_clr = 1'b1;
    @(negedge CLK);
    chk("coll_rdy", {31'd0, in_ready}, 32'd1);
    chk("coll_pre_sat", {31'd0, sat}, 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("coll_set_wins", {31'd0, sat}, 32'd1);
    @(posedge CLK); #1;
    sat_clr = 1'b0;
    @(negedge CLK);
    chk("coll_clr_alone", {31'd0, sat}, 32'd0);
    wc = -1;
    for (int c = 3; c <= 200; c++) begin
      @(negedge CLK);
      if (in_ready) begin
        wc = c;
        break;
      end
    end
    chk("coll_frame_rdy", wc, 133);

    start(-1);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("minus1_word", {16'd0, w}, 32'hFFFF);
    chk("minus1_sat", {31'd0, s1}, 32'd0);

    // Back-to-back with in_valid held high
    start(5);
    frame(1'b1, -5, w, nf, fl, ll, lc, gc, s1, rd);
    chk("b2b_word0", {16'd0, w}, 32'h0005);
    chk("b2b_spacing", rd, 133);
    chk("b2b_gap", gc, 4);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("b2b_word1", {16'd0, w}, 32'hFFFB);
    chk("b2b_first_low", fl, 1);

    // Reset one cycle at T+50 of a clipping frame
    start(70000);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("mid_t1_sat", {31'd0, sat}, 32'd1);
    repeat (49) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(negedge CLK);
    chk("mid_rdy_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0; din = -300; in_valid = 1'b1;
    @(negedge CLK);
    chk("mid_sync_n", {31'd0, dac_sync_n}, 32'd1);
    chk("mid_sclk",   {31'd0, dac_sclk}, 32'd0);
    chk("mid_busy",   {31'd0, busy}, 32'd0);
    chk("mid_sat",    {31'd0, sat}, 32'd0);
    frame(1'b0, 0, w, nf, fl, ll, lc, gc, s1, rd);
    chk("mid_new_word", {16'd0, w}, 32'hFED4);
    chk("mid_new_nfall", nf, 16);
    chk("mid_new_rdy", rd, 133);

    // 8-bit word, one-cycle half period
    @(posedge CLK); #1;
    din8 = -128; in_valid8 = 1'b1;
    @(negedge CLK);
    chk("c8_rdy", {31'd0, in_ready8}, 32'd1);
    ps8 = sclk8;
    @(posedge CLK); #1;
    in_valid8 = 1'b0;
    w = '0; nf = 0; ll = -1; lc = 0; gc = 0; rd = -1; s1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (sat8) s1 = 1'b1;
      if (ps8 && !sclk8) begin
        w = {w[14:0], sdata8};
        nf++;
      end
      if (!sync_n8) begin
        ll = c;
        lc++;
      end
      if (busy8 && sync_n8) gc++;
      ps8 = sclk8;
      if (in_ready8) begin
        rd = c;
        break;
      end
    end
    chk("c8_word", {16'd0, w}, 32'h0080);
    chk("c8_nfall", nf, 8);
    chk("c8_last_low", ll, 16);
    chk("c8_lowcnt", lc, 16);
    chk("c8_gap", gc, 1);
    chk("c8_ready_at", rd, 18);
    chk("c8_sat", {31'd0, s1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
